// File: rtl/pkg_dtypes.sv
// Shared types and default sizes for the dispatch stage and its IQueue consumers.
// The optional stall counter in u_dispatch is enabled by DISPATCH_PERF_CNT_EN.
package pkg_dtypes;

  localparam int DISP_NUM_EU     = 4;
  localparam int DISP_INSTR_W    = 64;
  localparam int DISP_BUF_DEPTH  = 2;
  localparam int DISP_IQ_CREDITS = 4;
  localparam int DISP_TAG_W      = 8;

  typedef struct packed {
    logic [DISP_NUM_EU-1:0]  eu_mask;
    logic [DISP_INSTR_W-1:0] instr;
  } disp_entry_t;

  typedef struct packed {
    logic [DISP_INSTR_W-1:0] instr;
    logic [DISP_TAG_W-1:0]   tag;
  } disp_bus_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/u_dispatch_rr_arb.sv
// Combinational round-robin select: first set bit of elig at or after rr_ptr, wrapping.
module u_dispatch_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      if (!found && elig[IDX_W'(j)]) begin
        grant[IDX_W'(j)] = 1'b1;
        grant_idx        = IDX_W'(j);
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/u_dispatch.sv
// Dispatch stage: small input FIFO, per-unit credits, round-robin steering to one IQueue.
// Define DISPATCH_PERF_CNT_EN to add the o_stall_cycles counter.
module u_dispatch
  import pkg_dtypes::*;
#(
  parameter int NUM_EXEC_UNITS = DISP_NUM_EU,
  parameter int INSTR_W        = DISP_INSTR_W,
  parameter int BUF_DEPTH      = DISP_BUF_DEPTH,
  parameter int IQ_CREDITS     = DISP_IQ_CREDITS,
  parameter int TAG_W          = DISP_TAG_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_instr_valid,
  output logic                      o_instr_ready,
  input  logic [INSTR_W-1:0]        i_instr,
  input  logic [NUM_EXEC_UNITS-1:0] i_eu_mask,
  input  logic                      i_flush,
  output logic [NUM_EXEC_UNITS-1:0] o_disp_valid,
  output logic [INSTR_W-1:0]        o_disp_instr,
  output logic [TAG_W-1:0]          o_disp_tag,
  input  logic [NUM_EXEC_UNITS-1:0] i_credit_ret,
  output logic                      o_illegal
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]               o_stall_cycles
`endif
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int CRED_W = $clog2(IQ_CREDITS + 1);
  localparam int IDX_W  = (NUM_EXEC_UNITS > 1) ? $clog2(NUM_EXEC_UNITS) : 1;

  logic [INSTR_W-1:0]        fifo_instr [BUF_DEPTH];
  logic [NUM_EXEC_UNITS-1:0] fifo_mask  [BUF_DEPTH];
  logic [PTR_W-1:0]          rd_ptr, wr_ptr;
  logic [CNT_W-1:0]          count;
  logic [CRED_W-1:0]         credit [NUM_EXEC_UNITS];
  logic [IDX_W-1:0]          rr_ptr, grant_idx;
  logic [TAG_W-1:0]          tag_cnt;
  logic [NUM_EXEC_UNITS-1:0] head_mask, elig, grant, cred_dec;
  logic                      non_empty, push, pop, disp, illegal_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign o_instr_ready = (count < CNT_W'(BUF_DEPTH));
  assign non_empty     = (count != '0);
  assign head_mask     = fifo_mask[rd_ptr];
  assign push          = i_instr_valid & o_instr_ready & ~i_flush;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_EXEC_UNITS; k++)
      elig[k] = non_empty & head_mask[k] & (credit[k] != '0);
  end

  u_dispatch_rr_arb #(
    .N     (NUM_EXEC_UNITS),
    .IDX_W (IDX_W)
  ) u_arb (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign disp        = (|grant) & ~i_flush;
  assign illegal_pop = non_empty & (head_mask == '0) & ~i_flush;
  assign pop         = disp | illegal_pop;
  assign cred_dec    = disp ? grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= i_instr;
      fifo_mask[wr_ptr]  <= i_eu_mask;
    end
  end

  // Simultaneous dispatch and return cancel; a return at full credit saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_EXEC_UNITS; k++) credit[k] <= CRED_W'(IQ_CREDITS);
    end else begin
      for (int k = 0; k < NUM_EXEC_UNITS; k++) begin
        if (i_credit_ret[k] && !cred_dec[k]) begin
          if (credit[k] != CRED_W'(IQ_CREDITS)) credit[k] <= credit[k] + 1'b1;
        end else if (cred_dec[k] && !i_credit_ret[k]) begin
          credit[k] <= credit[k] - 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < NUM_EXEC_UNITS; k++)
        assert (!(i_credit_ret[k] && !cred_dec[k] && credit[k] == CRED_W'(IQ_CREDITS)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_disp_valid <= '0;
      o_disp_instr <= '0;
      o_disp_tag   <= '0;
      o_illegal    <= 1'b0;
      tag_cnt      <= '0;
      rr_ptr       <= '0;
    end else begin
      o_disp_valid <= cred_dec;
      o_illegal    <= illegal_pop;
      if (disp) begin
        o_disp_instr <= fifo_instr[rd_ptr];
        o_disp_tag   <= tag_cnt;
        tag_cnt      <= tag_cnt + 1'b1;
        rr_ptr       <= IDX_W'(rr_next(32'(grant_idx), NUM_EXEC_UNITS));
      end
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic stall;
  assign stall = non_empty & (|head_mask) & ~(|elig);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      o_stall_cycles <= '0;
    else if (stall && o_stall_cycles != '1)
      o_stall_cycles <= o_stall_cycles + 1'b1;
  end
`endif

endmodule
